// File: rtl/hwpe_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_sel_ctrl
// Purpose  : Control stage in front of the HWPE subsystem. Owns the HWPE
//            enable/select outputs and only switches the selected HWPE once
//            the current one is idle (not busy, no outstanding TCDM traffic),
//            holding the enable low for GATE_CYCLES around every select
//            change. Programmed through a small register file on the
//            peripheral config bus:
//              0x00 CTRL        [0] EN_REQ, [8+:SEL_W] SEL_REQ        (rw)
//              0x04 STATUS      [0] en, [8+:SEL_W] sel, [18:16] state,
//                               [24] pending, [25] TO_ERR, [26] ILL_ERR
//                               (bits 25/26 write-1-to-clear)
//              0x08 OUTSTANDING outstanding TCDM transaction count   (ro)
//              0x0C             reads 0, writes ignored
// Options  : `define HWPE_SEL_CTRL_TIMEOUT_EN adds a DRAIN timeout
//            (parameter DRAIN_TIMEOUT) that aborts a stuck switch and sets
//            TO_ERR. Without it DRAIN waits indefinitely and TO_ERR reads 0.
// Ports    : clk, rst_n (async, active-low)
//            cfg_*        : config bus slave (req/gnt, one-cycle response)
//            hwpe_busy_i  : busy flag of the selected HWPE
//            tcdm_*       : HWPE TCDM handshake, monitored only
//            hwpe_en_o    : subsystem enable
//            hwpe_sel_o   : subsystem select
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_sel_ctrl #(
  parameter int NUM_HWPES       = 2,
  parameter int SEL_W           = 2,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int GATE_CYCLES     = 4
`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
  ,
  parameter int DRAIN_TIMEOUT   = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  // config bus
  input  logic                cfg_req_i,
  input  logic [31:0]         cfg_add_i,
  input  logic                cfg_wen_i,
  input  logic [31:0]         cfg_wdata_i,
  input  logic [3:0]          cfg_be_i,
  input  logic [ID_WIDTH-1:0] cfg_id_i,
  output logic                cfg_gnt_o,
  output logic [31:0]         cfg_r_rdata_o,
  output logic                cfg_r_valid_o,
  output logic [ID_WIDTH-1:0] cfg_r_id_o,
  // HWPE status / TCDM monitor
  input  logic                hwpe_busy_i,
  input  logic                tcdm_req_i,
  input  logic                tcdm_gnt_i,
  input  logic                tcdm_r_valid_i,
  // HWPE subsystem control
  output logic                hwpe_en_o,
  output logic [SEL_W-1:0]    hwpe_sel_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_GATED = 3'd4;

  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int GCNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [OCNT_W-1:0] OCNT_MAX  = OCNT_W'(MAX_OUTSTANDING);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GATE_CYCLES - 1);
  localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(NUM_HWPES);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_OUTST  = 2'd2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [GCNT_W-1:0] gate_cnt;
  logic [GCNT_W-1:0] gate_cnt_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic              gate_last;

  logic              en_req;
  logic [SEL_W-1:0]  sel_req;
  logic              en_req_mrg;
  logic [SEL_W-1:0]  sel_req_mrg;

  logic              ill_err;
  logic              to_err;
  logic              timeout_hit;

  logic [OCNT_W-1:0] outst;
  logic              tcdm_inc;
  logic              tcdm_dec;
  logic              drain_done;
  logic              pending;

  logic [1:0]        reg_idx;
  logic              wr_ok;
  logic              ctrl_wr;
  logic              status_wr;
  logic [SEL_W-1:0]  wr_sel;
  logic              wr_sel_legal;
  logic              ctrl_wr_ok;
  logic              ctrl_wr_bad;
  logic [31:0]       rd_mux;

  // Only address bits [3:2] are decoded; the rest of the bus is don't-care.
  logic              unused_cfg;
  assign unused_cfg = ^{cfg_add_i[31:4], cfg_add_i[1:0], cfg_wdata_i};

  // --------------------------------------------------------------------------
  // Config bus decode
  // --------------------------------------------------------------------------
  assign cfg_gnt_o    = cfg_req_i;
  assign reg_idx      = cfg_add_i[3:2];
  assign wr_ok        = cfg_req_i & ~cfg_wen_i & (cfg_be_i == 4'hF);
  assign ctrl_wr      = wr_ok & (reg_idx == REG_CTRL);
  assign status_wr    = wr_ok & (reg_idx == REG_STATUS);
  assign wr_sel       = cfg_wdata_i[8 +: SEL_W];
  assign wr_sel_legal = ({1'b0, wr_sel} < SEL_LIMIT);
  assign ctrl_wr_ok   = ctrl_wr & wr_sel_legal;
  assign ctrl_wr_bad  = ctrl_wr & ~wr_sel_legal;

  // Request values as they will be after this cycle, so that a CTRL write
  // landing on the very cycle a sel update happens is not lost.
  assign en_req_mrg  = ctrl_wr_ok ? cfg_wdata_i[0] : en_req;
  assign sel_req_mrg = ctrl_wr_ok ? wr_sel         : sel_req;

  // --------------------------------------------------------------------------
  // Outstanding TCDM transaction counter
  // --------------------------------------------------------------------------
  assign tcdm_inc = tcdm_req_i & tcdm_gnt_i;
  assign tcdm_dec = tcdm_r_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else if (tcdm_inc && !tcdm_dec && (outst != OCNT_MAX)) begin
      outst <= outst + OCNT_W'(1);
    end else if (tcdm_dec && !tcdm_inc && (outst != '0)) begin
      outst <= outst - OCNT_W'(1);
    end
  end

  assign drain_done = ~hwpe_busy_i & (outst == '0);
  assign gate_last  = (gate_cnt == GCNT_LAST);
  assign pending    = (state == ST_SETUP) | (state == ST_DRAIN) |
                      (state == ST_GATED);

  // --------------------------------------------------------------------------
  // Optional drain timeout
  // --------------------------------------------------------------------------
`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
  localparam int TCNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DRAIN_TIMEOUT - 1);

  logic [TCNT_W-1:0] to_cnt;

  // Fires on the DRAIN_TIMEOUT-th cycle spent in DRAIN, unless the drain
  // completes in that same cycle (completion wins).
  assign timeout_hit = (state == ST_DRAIN) & ~drain_done & (to_cnt == TCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if ((state == ST_DRAIN) && !timeout_hit) begin
        to_cnt <= to_cnt + TCNT_W'(1);
      end else begin
        to_cnt <= '0;
      end
      if (timeout_hit) begin
        to_err <= 1'b1;
      end else if (status_wr && cfg_wdata_i[25]) begin
        to_err <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign to_err      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Request registers and illegal-select flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_req  <= 1'b0;
      sel_req <= '0;
      ill_err <= 1'b0;
    end else begin
      if (timeout_hit) begin
        // Abort the switch: make the request match what is running.
        en_req  <= 1'b1;
        sel_req <= hwpe_sel_o;
      end else if (ctrl_wr_ok) begin
        en_req  <= cfg_wdata_i[0];
        sel_req <= wr_sel;
      end
      if (ctrl_wr_bad) begin
        ill_err <= 1'b1;
      end else if (status_wr && cfg_wdata_i[26]) begin
        ill_err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Switch FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    sel_nxt      = hwpe_sel_o;
    gate_cnt_nxt = '0;
    case (state)
      ST_OFF: begin
        if (ctrl_wr_ok && cfg_wdata_i[0]) begin
          state_nxt = ST_SETUP;
          sel_nxt   = wr_sel;
        end
      end
      ST_SETUP: begin
        if (gate_last) begin
          // Enable is still low here, so a select written during SETUP can
          // be picked up safely before entering RUN.
          state_nxt = ST_RUN;
          sel_nxt   = sel_req_mrg;
        end else begin
          gate_cnt_nxt = gate_cnt + GCNT_W'(1);
        end
      end
      ST_RUN: begin
        if (ctrl_wr_ok && (!cfg_wdata_i[0] || (wr_sel != hwpe_sel_o))) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_nxt = ST_GATED;
        end else if (timeout_hit) begin
          state_nxt = ST_RUN;
        end
      end
      ST_GATED: begin
        if (gate_last) begin
          sel_nxt   = sel_req_mrg;
          state_nxt = en_req_mrg ? ST_RUN : ST_OFF;
        end else begin
          gate_cnt_nxt = gate_cnt + GCNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
  end

  // Enable is registered from the next state so it is glitch-free and moves
  // on the same edge as the select; select only ever changes on edges that
  // leave OFF, SETUP or GATED, where enable was low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      gate_cnt   <= '0;
      hwpe_en_o  <= 1'b0;
      hwpe_sel_o <= '0;
    end else begin
      state      <= state_nxt;
      gate_cnt   <= gate_cnt_nxt;
      hwpe_en_o  <= (state_nxt == ST_RUN) | (state_nxt == ST_DRAIN);
      hwpe_sel_o <= sel_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and response channel
  // --------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_CTRL: begin
        rd_mux[0]          = en_req;
        rd_mux[8 +: SEL_W] = sel_req;
      end
      REG_STATUS: begin
        rd_mux[0]          = hwpe_en_o;
        rd_mux[8 +: SEL_W] = hwpe_sel_o;
        rd_mux[18:16]      = state;
        rd_mux[24]         = pending;
        rd_mux[25]         = to_err;
        rd_mux[26]         = ill_err;
      end
      REG_OUTST: begin
        rd_mux[OCNT_W-1:0] = outst;
      end
      default: begin
        rd_mux = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_r_valid_o <= 1'b0;
      cfg_r_id_o    <= '0;
      cfg_r_rdata_o <= '0;
    end else begin
      cfg_r_valid_o <= cfg_req_i;
      if (cfg_req_i) begin
        cfg_r_id_o <= cfg_id_i;
      end
      cfg_r_rdata_o <= (cfg_req_i && cfg_wen_i) ? rd_mux : 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpe_sel_ctrl
// Purpose  : Directed self-checking bench for hwpe_sel_ctrl. Config reads
//            push their expected data/ID to a scoreboard queue; a response
//            monitor pops and compares on every cfg_r_valid_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_sel_ctrl;

  localparam int ID_W  = 8;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_req;
  logic [31:0]      cfg_add;
  logic             cfg_wen;
  logic [31:0]      cfg_wdata;
  logic [3:0]       cfg_be;
  logic [ID_W-1:0]  cfg_id;
  logic             cfg_gnt;
  logic [31:0]      cfg_r_rdata;
  logic             cfg_r_valid;
  logic [ID_W-1:0]  cfg_r_id;
  logic             hwpe_busy;
  logic             tcdm_req;
  logic             tcdm_gnt;
  logic             tcdm_r_valid;
  logic             hwpe_en;
  logic [SEL_W-1:0] hwpe_sel;

  hwpe_sel_ctrl #(
    .NUM_HWPES       (2),
    .SEL_W           (SEL_W),
    .ID_WIDTH        (ID_W),
    .MAX_OUTSTANDING (16),
    .GATE_CYCLES     (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_req_i      (cfg_req),
    .cfg_add_i      (cfg_add),
    .cfg_wen_i      (cfg_wen),
    .cfg_wdata_i    (cfg_wdata),
    .cfg_be_i       (cfg_be),
    .cfg_id_i       (cfg_id),
    .cfg_gnt_o      (cfg_gnt),
    .cfg_r_rdata_o  (cfg_r_rdata),
    .cfg_r_valid_o  (cfg_r_valid),
    .cfg_r_id_o     (cfg_r_id),
    .hwpe_busy_i    (hwpe_busy),
    .tcdm_req_i     (tcdm_req),
    .tcdm_gnt_i     (tcdm_gnt),
    .tcdm_r_valid_i (tcdm_r_valid),
    .hwpe_en_o      (hwpe_en),
    .hwpe_sel_o     (hwpe_sel)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_id_q[$];
  string       exp_tag_q[$];
  logic [7:0]  next_id = 8'h10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n clock cycles, landing 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_xfer(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [31:0] exp_rd, input string tag);
    @(posedge clk);
    #1;
    cfg_req   = 1'b1;
    cfg_wen   = ~is_wr;
    cfg_add   = addr;
    cfg_wdata = data;
    cfg_be    = be;
    cfg_id    = next_id;
    exp_data_q.push_back(is_wr ? 32'h0 : exp_rd);
    exp_id_q.push_back(next_id);
    exp_tag_q.push_back(tag);
    next_id = next_id + 8'd1;
    #1;
    check({tag, "_gnt"}, {31'h0, cfg_gnt}, 32'h1);
    @(posedge clk);
    #1;
    cfg_req   = 1'b0;
    cfg_wen   = 1'b1;
    cfg_wdata = 32'h0;
    cfg_be    = 4'h0;
    check({tag, "_rvalid"}, {31'h0, cfg_r_valid}, 32'h1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
    cfg_xfer(1'b1, addr, data, 4'hF, 32'h0, tag);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    cfg_xfer(1'b0, addr, 32'h0, 4'hF, exp, tag);
  endtask

  // Response monitor / scoreboard pop
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cfg_r_valid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_resp", 32'h1, 32'h0);
      end else begin
        automatic logic [31:0] ed = exp_data_q.pop_front();
        automatic logic [7:0]  ei = exp_id_q.pop_front();
        automatic string       et = exp_tag_q.pop_front();
        check({et, "_rdata"}, cfg_r_rdata, ed);
        check({et, "_rid"}, {24'h0, cfg_r_id}, {24'h0, ei});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_req = 1'b0; cfg_add = 32'h0; cfg_wen = 1'b1; cfg_wdata = 32'h0;
    cfg_be = 4'h0; cfg_id = '0; hwpe_busy = 1'b0; tcdm_req = 1'b0; tcdm_gnt = 1'b0;
    tcdm_r_valid = 1'b0;

    // ---------------- reset state ----------------
    step(3);
    check("rst_en", {31'h0, hwpe_en}, 32'h0);
    check("rst_sel", {30'h0, hwpe_sel}, 32'h0);
    check("rst_rvalid", {31'h0, cfg_r_valid}, 32'h0);
    check("rst_rdata", cfg_r_rdata, 32'h0);
    check("rst_rid", {24'h0, cfg_r_id}, 32'h0);
    rst_n = 1'b1;
    step(1);
    check("idle_gnt", {31'h0, cfg_gnt}, 32'h0);
    rd(32'h4, 32'h0, "rst_status");
    rd(32'h0, 32'h0, "rst_ctrl");
    rd(32'h8, 32'h0, "rst_outst");

    // ---------------- enable with sel=1 ----------------
    wr(32'h0, 32'h101, "ctrl_en1");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("setup_en_%0d", i), {31'h0, hwpe_en}, 32'h0);
      check($sformatf("setup_sel_%0d", i), {30'h0, hwpe_sel}, 32'h1);
      step(1);
    end
    check("run_en", {31'h0, hwpe_en}, 32'h1);
    rd(32'h4, 32'h00020101, "status_run1");
    rd(32'h0, 32'h101, "ctrl_rb1");

    // ---------------- switch to 0 while busy ----------------
    hwpe_busy = 1'b1;
    wr(32'h0, 32'h001, "ctrl_sw0");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_en_%0d", i), {31'h0, hwpe_en}, 32'h1);
      check($sformatf("drain_sel_%0d", i), {30'h0, hwpe_sel}, 32'h1);
      step(1);
    end
    rd(32'h4, 32'h01030101, "status_drain");
    hwpe_busy = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("gated_en_%0d", i), {31'h0, hwpe_en}, 32'h0);
      if (i < 3) check($sformatf("gated_sel_%0d", i), {30'h0, hwpe_sel}, 32'h1);
      step(1);
    end
    check("sw0_en", {31'h0, hwpe_en}, 32'h1);
    check("sw0_sel", {30'h0, hwpe_sel}, 32'h0);

    // ---------------- outstanding counter ----------------
    tcdm_req = 1'b1; tcdm_gnt = 1'b1;
    step(2);
    tcdm_r_valid = 1'b1;
    step(1);
    tcdm_req = 1'b0; tcdm_gnt = 1'b0;
    step(1);
    tcdm_r_valid = 1'b0;
    rd(32'h8, 32'h1, "outst_1");
    wr(32'h0, 32'h101, "ctrl_sw1");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("outst_wait_en_%0d", i), {31'h0, hwpe_en}, 32'h1);
      step(1);
    end
    rd(32'h4, 32'h01030001, "status_drain_outst");
    tcdm_r_valid = 1'b1;
    step(1);
    tcdm_r_valid = 1'b0;
    check("last_rvalid_en", {31'h0, hwpe_en}, 32'h1);
    step(1);
    check("outst_gated_en", {31'h0, hwpe_en}, 32'h0);
    step(4);
    check("sw1_en", {31'h0, hwpe_en}, 32'h1);
    check("sw1_sel", {30'h0, hwpe_sel}, 32'h1);

    // saturation and underflow
    tcdm_req = 1'b1; tcdm_gnt = 1'b1;
    step(20);
    tcdm_req = 1'b0; tcdm_gnt = 1'b0;
    rd(32'h8, 32'h10, "outst_sat");
    tcdm_r_valid = 1'b1;
    step(20);
    tcdm_r_valid = 1'b0;
    rd(32'h8, 32'h0, "outst_underflow");

    // ---------------- illegal select, be gating, W1C ----------------
    wr(32'h0, 32'h301, "ctrl_ill");
    step(1);
    rd(32'h4, 32'h04020101, "status_ill");
    rd(32'h0, 32'h101, "ctrl_after_ill");
    cfg_xfer(1'b1, 32'h0, 32'h000, 4'h3, 32'h0, "ctrl_partial_be");
    rd(32'h4, 32'h04020101, "status_after_be");
    wr(32'h4, 32'h04000000, "status_w1c");
    rd(32'h4, 32'h00020101, "status_cleared");
    wr(32'hC, 32'hFFFFFFFF, "reg3_wr");
    rd(32'hC, 32'h0, "reg3_rd");

    // ---------------- writes during GATED ----------------
    wr(32'h0, 32'h001, "ctrl_sw0b");
    wr(32'h0, 32'h101, "gated_wr1");
    check("gated_wr1_en", {31'h0, hwpe_en}, 32'h0);
    wr(32'h0, 32'h000, "gated_wr2");
    check("gated_wr2_en", {31'h0, hwpe_en}, 32'h0);
    step(2);
    check("off_en", {31'h0, hwpe_en}, 32'h0);
    check("off_sel", {30'h0, hwpe_sel}, 32'h0);
    rd(32'h4, 32'h0, "status_off");

`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
    // ---------------- drain timeout ----------------
    begin
      int en_drops;
      en_drops = 0;
      wr(32'h0, 32'h001, "to_enable");
      step(5);
      hwpe_busy = 1'b1;
      wr(32'h0, 32'h101, "to_switch");
      for (int i = 0; i < 1040; i++) begin
        if (hwpe_en !== 1'b1) en_drops++;
        step(1);
      end
      check("to_en_held", en_drops, 0);
      rd(32'h4, 32'h02020001, "to_status");
      rd(32'h0, 32'h001, "to_ctrl_reload");
      hwpe_busy = 1'b0;
      wr(32'h4, 32'h02000000, "to_w1c");
      rd(32'h4, 32'h00020001, "to_cleared");
    end
`endif

    // ---------------- async reset mid-operation ----------------
    wr(32'h0, 32'h101, "pre_rst_en");
    step(6);
    check("pre_rst_en", {31'h0, hwpe_en}, 32'h1);
    step(2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_en", {31'h0, hwpe_en}, 32'h0);
    check("arst_sel", {30'h0, hwpe_sel}, 32'h0);
    check("arst_rvalid", {31'h0, cfg_r_valid}, 32'h0);
    step(2);
    rst_n = 1'b1;
    rd(32'h4, 32'h0, "post_rst_status");
    rd(32'h0, 32'h0, "post_rst_ctrl");

    step(3);
    check("sb_empty", exp_data_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
